// File: rtl/param_seq_mult_if.sv
// Handshake and operand/result bundle for param_seq_mult.
interface param_seq_mult_if #(
    parameter int unsigned WIDTH = 8
);
    logic               start;
    logic               signed_mode;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] product;

    modport master (
        output start, signed_mode, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, signed_mode, a, b,
        output busy, done, product
    );
endinterface

// File: rtl/param_seq_mult.sv
// Sequential shift-add multiplier, one multiplier bit per clock, signed or unsigned per op.
// Define SEQ_MULT_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are zero.
module param_seq_mult #(
    parameter int unsigned WIDTH = 8
) (
    input logic             clk,
    input logic             rst,
    param_seq_mult_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned AW    = 2 * WIDTH + 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             state_q, state_d;
    logic [AW-1:0]      acc_q, acc_d;      // {A, Q}
    logic [WIDTH-1:0]   m_q, m_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic [PW-1:0]      product_q, product_d;

    logic [WIDTH+1:0]   sum;
    logic [AW-1:0]      step;
    logic [PW-1:0]      mag;
    logic               last;
    logic [WIDTH-1:0]   abs_a, abs_b;

    always_comb begin
        sum  = {1'b0, acc_q[AW-1:WIDTH]} + (acc_q[0] ? {2'b00, m_q} : '0);
        step = {sum, acc_q[WIDTH-1:1]};
`ifdef SEQ_MULT_EARLY_TERM_EN
        // Done once no unprocessed multiplier bit above the current one is set.
        last = 1'b1;
        for (int unsigned i = 1; i < WIDTH; i++) begin
            if (CNT_W'(i) < cnt_q && acc_q[i]) begin
                last = 1'b0;
            end
        end
        mag = PW'(step >> (cnt_q - CNT_W'(1)));
`else
        last = (cnt_q == CNT_W'(1));
        mag  = step[PW-1:0];
`endif
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        m_d       = m_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        product_d = product_q;
        abs_a     = (bus.signed_mode && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        abs_b     = (bus.signed_mode && bus.b[WIDTH-1]) ? -bus.b : bus.b;
        unique case (state_q)
            StIdle, StDone: begin
                if (bus.start) begin
                    state_d = StRun;
                    m_d     = abs_a;
                    acc_d   = AW'(abs_b);
                    cnt_d   = CNT_W'(WIDTH);
                    neg_d   = bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                acc_d = step;
                cnt_d = cnt_q - CNT_W'(1);
                if (last) begin
                    product_d = neg_q ? -mag : mag;
                    state_d   = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            m_q       <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            m_q       <= m_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            product_q <= product_d;
        end
    end

    assign bus.busy    = (state_q == StRun);
    assign bus.done    = (state_q == StDone);
    assign bus.product = product_q;
endmodule
